// File: rtl/diff_accum.sv
// Sum of absolute differences over a window of COUNT accepted samples, framed by Start.
// Build option DIFF_ACCUM_SAT_EN: saturating accumulator with a sticky Overflow flag.
module diff_accum #(
  parameter int DATAWIDTH = 8,
  parameter int COUNT     = 16,
  parameter int ACCWIDTH  = 12
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Start,
  input  logic                        InValid,
  input  logic signed [DATAWIDTH-1:0] Diff,
  output logic                        InReady,
  output logic [ACCWIDTH-1:0]         Sum,
  output logic                        Done,
  output logic                        Busy,
  output logic                        Overflow
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ACCWIDTH-1:0]   acc;
  logic [CNT_W-1:0]      cnt;
  logic                  ovf_work;
  logic [ACCWIDTH:0]     add_res;
  logic                  ovf_nxt;
  logic                  accept, last, clear;

  // Magnitude as unsigned DATAWIDTH bits, so the most negative input maps to 2^(DATAWIDTH-1).
  function automatic logic [DATAWIDTH-1:0] abs_val(input logic signed [DATAWIDTH-1:0] d);
    abs_val = d[DATAWIDTH-1] ? (~$unsigned(d) + DATAWIDTH'(1)) : $unsigned(d);
  endfunction

  // Returns {saturated_this_add, new_acc}.
`ifdef DIFF_ACCUM_SAT_EN
  function automatic logic [ACCWIDTH:0] acc_add(input logic [ACCWIDTH-1:0] a,
                                                input logic [DATAWIDTH-1:0] m);
    logic [ACCWIDTH:0] w;
    w = {1'b0, a} + (ACCWIDTH+1)'(m);
    acc_add = w[ACCWIDTH] ? {1'b1, {ACCWIDTH{1'b1}}} : w;
  endfunction
`else
  function automatic logic [ACCWIDTH:0] acc_add(input logic [ACCWIDTH-1:0] a,
                                                input logic [DATAWIDTH-1:0] m);
    acc_add = {1'b0, a + ACCWIDTH'(m)};
  endfunction
`endif

  assign accept  = (state == RUN) && InValid;
  assign last    = accept && (cnt == LAST);
  assign clear   = ((state == IDLE) || (state == DONE)) && Start;
  assign add_res = acc_add(acc, abs_val(Diff));
  assign ovf_nxt = ovf_work | add_res[ACCWIDTH];

  assign InReady = (state == RUN);
  assign Busy    = (state == RUN);
  assign Done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = Start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      ovf_work <= 1'b0;
      Sum      <= '0;
      Overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        acc      <= '0;
        cnt      <= '0;
        ovf_work <= 1'b0;
      end else if (accept) begin
        acc      <= add_res[ACCWIDTH-1:0];
        cnt      <= cnt + CNT_W'(1);
        ovf_work <= ovf_nxt;
      end
      // Result registers load on the closing sample so they are valid during DONE.
      if (last) begin
        Sum      <= add_res[ACCWIDTH-1:0];
        Overflow <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_diff_accum.sv
// Scoreboard bench for diff_accum (COUNT=4, ACCWIDTH=8); follows DIFF_ACCUM_SAT_EN if defined.
module tb_diff_accum;
  localparam int DW  = 8;
  localparam int CNT = 4;
  localparam int AW  = 8;

  logic                 Clk = 1'b0;
  logic                 Rst = 1'b0;
  logic                 Start = 1'b0;
  logic                 InValid = 1'b0;
  logic signed [DW-1:0] Diff = '0;
  logic                 InReady, Done, Busy, Overflow;
  logic [AW-1:0]        Sum;

  typedef struct {
    logic [AW-1:0] sum;
    logic          ovf;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            m_state = 0;
  int            m_cnt = 0;
  int            m_total = 0;
  logic [AW-1:0] held_sum = '0;
  logic          held_ovf = 1'b0;

  diff_accum #(.DATAWIDTH(DW), .COUNT(CNT), .ACCWIDTH(AW)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .InValid(InValid), .Diff(Diff),
    .InReady(InReady), .Sum(Sum), .Done(Done), .Busy(Busy), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  function automatic exp_t finalize(input int total);
    exp_t e;
    int   w;
`ifdef DIFF_ACCUM_SAT_EN
    if (total > (1 << AW) - 1) begin
      e.sum = '1;
      e.ovf = 1'b1;
    end else begin
      w     = total;
      e.sum = w[AW-1:0];
      e.ovf = 1'b0;
    end
`else
    w     = total % (1 << AW);
    e.sum = w[AW-1:0];
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  function automatic int absd(input int d);
    return (d < 0) ? -d : d;
  endfunction

  // Drive one cycle, advance the model across the same edge, then check outputs.
  task automatic cycle(input string tag, input bit st, input bit v, input int d);
    exp_t e;
    logic exp_run, exp_done;
    Start   = st;
    InValid = v;
    Diff    = d[DW-1:0];
    case (m_state)
      0: if (st) begin m_state = 1; m_cnt = 0; m_total = 0; end
      1: if (v) begin
        m_total += absd(d);
        m_cnt++;
        if (m_cnt == CNT) begin
          e = finalize(m_total);
          sb.push_back(e);
          held_sum = e.sum;
          held_ovf = e.ovf;
          m_state  = 2;
        end
      end
      default: begin
        if (st) begin m_state = 1; m_cnt = 0; m_total = 0; end
        else m_state = 0;
      end
    endcase
    exp_run  = (m_state == 1);
    exp_done = (m_state == 2);
    @(posedge Clk);
    #1;
    checks++;
    if (Busy !== exp_run || InReady !== exp_run) begin
      failures++;
      $display("FAIL %s busy/ready got=%b/%b exp=%b", tag, Busy, InReady, exp_run);
    end
    checks++;
    if (Done !== exp_done) begin
      failures++;
      $display("FAIL %s done got=%b exp=%b", tag, Done, exp_done);
    end
    if (Done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL %s unexpected done sum=%0d", tag, Sum);
      end else begin
        e = sb.pop_front();
        if (Sum !== e.sum || Overflow !== e.ovf) begin
          failures++;
          $display("FAIL %s result got sum=%0d ovf=%b exp sum=%0d ovf=%b",
                   tag, Sum, Overflow, e.sum, e.ovf);
        end
      end
    end
    checks++;
    if (Sum !== held_sum || Overflow !== held_ovf) begin
      failures++;
      $display("FAIL %s hold got sum=%0d ovf=%b exp sum=%0d ovf=%b",
               tag, Sum, Overflow, held_sum, held_ovf);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_cnt    = 0;
    m_total  = 0;
    held_sum = '0;
    held_ovf = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (InReady !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Overflow !== 1'b0 || Sum !== '0) begin
      failures++;
      $display("FAIL %s outputs got rdy=%b busy=%b done=%b ovf=%b sum=%0d exp all 0",
               tag, InReady, Busy, Done, Overflow, Sum);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Start   = i[0];
      InValid = ~i[0];
      Diff    = DW'($urandom_range(0, 255));
      @(posedge Clk);
      #1;
      check_zero("reset_hold");
    end
    Start = 1'b0; InValid = 1'b0; Diff = '0;
    Rst = 1'b1;
    model_reset();
    sb.delete();
    cycle("reset_idle", 0, 1, 9);
  endtask

  task automatic test_basic();
    cycle("basic_start", 1, 0, 0);
    cycle("basic_s0", 0, 1, 3);
    cycle("basic_s1", 0, 1, -5);
    cycle("basic_s2", 0, 1, 0);
    cycle("basic_s3", 0, 1, 7);
    cycle("basic_idle", 0, 0, 0);
  endtask

  task automatic test_abort();
    cycle("abort_start", 1, 0, 0);
    cycle("abort_s0", 0, 1, 10);
    cycle("abort_s1", 0, 1, 20);
    Rst = 1'b0;
    #1;
    check_zero("abort_async");
    @(posedge Clk);
    #1;
    check_zero("abort_held");
    Rst = 1'b1;
    model_reset();
    sb.delete();
    for (int i = 0; i < 4; i++) cycle("abort_after", 0, 1, 5);
  endtask

  task automatic test_stall();
    int vpat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int dpat[7] = '{-10, 99, -99, 20, -3, 55, 4};
    cycle("stall_start", 1, 0, 0);
    for (int i = 0; i < 7; i++) cycle("stall", 0, vpat[i] != 0, dpat[i]);
    cycle("stall_idle", 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    cycle("b2b_start", 1, 0, 0);
    cycle("b2b_w1", 1, 1, 50);
    cycle("b2b_w1", 1, 1, 50);
    cycle("b2b_w1", 1, 1, -50);
    cycle("b2b_w1", 1, 1, 50);
    cycle("b2b_restart", 1, 1, 9);
    for (int i = 1; i <= 4; i++) cycle("b2b_w2", 0, 1, i);
    cycle("b2b_idle", 0, 0, 0);
  endtask

  task automatic test_extreme();
    cycle("ext_start", 1, 0, 0);
    cycle("ext_min", 0, 1, -128);
    for (int i = 0; i < 3; i++) cycle("ext_zero", 0, 1, 0);
    cycle("ext_start2", 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle("ext_allmin", 0, 1, -128);
    cycle("ext_idle", 0, 0, 0);
  endtask

  task automatic test_overflow();
    cycle("ovf_start", 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle("ovf_100", 0, 1, 100);
    cycle("edge_start", 1, 0, 0);
    cycle("edge_s", 0, 1, 127);
    cycle("edge_s", 0, 1, -127);
    cycle("edge_s", 0, 1, 1);
    cycle("edge_s", 0, 1, 0);
    cycle("edge_idle", 0, 0, 0);
    cycle("edge_idle", 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_stall();
    test_back_to_back();
    test_extreme();
    test_overflow();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain pending=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
